// File: rtl/filter_bank_pkg.sv
// Shared types and helpers for the loadable convolution filter bank.
// Linear weight index order is channel fastest, then column, then row.
package filter_bank_pkg;

  typedef enum logic {IDLE, LOAD} fb_state_t;

  localparam int WIDTH_DEF = 8;
  localparam int K_DEF     = 3;
  localparam int C_DEF     = 3;

  typedef struct packed {
    int row;
    int col;
    int ch;
  } rcc_t;

  function automatic rcc_t idx2rcc(input int idx, input int k, input int c);
    rcc_t p;
    p.ch  = idx % c;
    p.col = (idx / c) % k;
    p.row = idx / (c * k);
    return p;
  endfunction

endpackage

// File: rtl/filter_bank_if.sv
// Weight-load bus of the filter bank: slot selection, abort, word handshake and status.
interface filter_bank_if
  import filter_bank_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int NUM_FILTERS = 4
);
  localparam int SEL_W = $clog2(NUM_FILTERS);

  logic             load_start;
  logic [SEL_W-1:0] load_slot;
  logic             load_abort;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             load_busy;
  logic             load_done;
  logic             load_err;

  modport master (
    output load_start, load_slot, load_abort, wr_valid, wr_data,
    input  wr_ready, load_busy, load_done, load_err
  );

  modport slave (
    input  load_start, load_slot, load_abort, wr_valid, wr_data,
    output wr_ready, load_busy, load_done, load_err
  );

endinterface

// File: rtl/filter_load_ctrl.sv
// Load sequencer: IDLE/LOAD FSM, word counter, target-slot latch and done/err pulses.
module filter_load_ctrl
  import filter_bank_pkg::*;
#(
  parameter int K           = K_DEF,
  parameter int C           = C_DEF,
  parameter int NUM_FILTERS = 4,
  localparam int N          = K * K * C,
  localparam int SEL_W      = $clog2(NUM_FILTERS),
  localparam int CNT_W      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  filter_bank_if.slave     lb,
  output logic             start_fire,
  output logic [SEL_W-1:0] start_slot,
  output logic             wr_en,
  output logic [SEL_W-1:0] wr_slot,
  output logic [CNT_W-1:0] wr_idx,
  output logic             complete
);

  localparam logic [SEL_W:0] NF = (SEL_W + 1)'(NUM_FILTERS);

  fb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] slot_q;
  logic             done_q, err_q;
  logic             slot_ok, hs, last;

  assign slot_ok = {1'b0, lb.load_slot} < NF;
  assign hs      = lb.wr_valid && (state_q == LOAD);
  assign last    = hs && (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d    = state_q;
    start_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (lb.load_start && slot_ok) begin
          state_d    = LOAD;
          start_fire = 1'b1;
        end
      end
      LOAD: begin
        // The final word wins over a simultaneous abort; both end the load.
        if (last || lb.load_abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      err_q   <= (state_q == IDLE) && lb.load_start && !slot_ok;
      if (start_fire) begin
        cnt_q  <= '0;
        slot_q <= lb.load_slot;
      end else if (hs) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign lb.wr_ready  = (state_q == LOAD);
  assign lb.load_busy = (state_q == LOAD);
  assign lb.load_done = done_q;
  assign lb.load_err  = err_q;

  assign start_slot = lb.load_slot;
  assign wr_en      = hs;
  assign wr_slot    = slot_q;
  assign wr_idx     = cnt_q;
  assign complete   = last;

endmodule

// File: rtl/filter_bank.sv
// Bank of NUM_FILTERS KxKxC weight kernels with per-slot valid tracking and a
// one-cycle registered read that presents a whole kernel as [row][col][channel].
module filter_bank
  import filter_bank_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int K           = K_DEF,
  parameter int C           = C_DEF,
  parameter int NUM_FILTERS = 4,
  localparam int N          = K * K * C,
  localparam int SEL_W      = $clog2(NUM_FILTERS),
  localparam int CNT_W      = $clog2(N)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  filter_bank_if.slave                           lb,
  input  logic                                   rd_valid,
  input  logic [SEL_W-1:0]                       rd_slot,
  output logic [K-1:0][K-1:0][C-1:0][WIDTH-1:0]  kernel_out,
  output logic                                   out_valid,
  output logic                                   out_err,
  output logic [NUM_FILTERS-1:0]                 slot_valid
);

  localparam logic [SEL_W:0] NF = (SEL_W + 1)'(NUM_FILTERS);

  logic [WIDTH-1:0] mem [NUM_FILTERS][K][K][C];
  logic [WIDTH-1:0] kernel_p1 [K][K][C];
  logic             vld_p1, err_p1;

  logic             start_fire, wr_en, complete, rd_ok;
  logic [SEL_W-1:0] start_slot, wr_slot;
  logic [CNT_W-1:0] wr_idx;
  rcc_t             wr_pos;

  filter_load_ctrl #(
    .K           (K),
    .C           (C),
    .NUM_FILTERS (NUM_FILTERS)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .lb         (lb),
    .start_fire (start_fire),
    .start_slot (start_slot),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .wr_idx     (wr_idx),
    .complete   (complete)
  );

  assign wr_pos = idx2rcc(int'(wr_idx), K, C);
  assign rd_ok  = ({1'b0, rd_slot} < NF) && slot_valid[rd_slot];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      if (start_fire) slot_valid[start_slot] <= 1'b0;
      if (complete)   slot_valid[wr_slot]    <= 1'b1;
      vld_p1 <= rd_valid;
      err_p1 <= rd_valid && !rd_ok;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      for (genvar ch = 0; ch < C; ch++) begin : g_ch
        always_ff @(posedge clk) begin
          if (wr_en && wr_pos.row == r && wr_pos.col == c && wr_pos.ch == ch)
            mem[wr_slot][r][c][ch] <= lb.wr_data;
        end

        // Read stage p1: slot contents, or zeros for an unusable slot.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            kernel_p1[r][c][ch] <= '0;
          else if (rd_valid)
            kernel_p1[r][c][ch] <= rd_ok ? mem[rd_slot][r][c][ch] : '0;
        end

        assign kernel_out[r][c][ch] = kernel_p1[r][c][ch];
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_err   = err_p1;

endmodule

// File: tb/tb_filter_bank.sv
// Randomized self-checking bench for filter_bank against a slot-level model of the bank.
module tb_filter_bank;
  import filter_bank_pkg::*;

  localparam int W  = 8;
  localparam int K  = 3;
  localparam int C  = 3;
  localparam int NF = 5;
  localparam int N  = K * K * C;
  localparam int SW = $clog2(NF);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                             rd_valid;
  logic [SW-1:0]                    rd_slot;
  logic [K-1:0][K-1:0][C-1:0][W-1:0] kernel_out;
  logic                             out_valid, out_err;
  logic [NF-1:0]                    slot_valid;

  filter_bank_if #(.WIDTH(W), .NUM_FILTERS(NF)) bus ();

  filter_bank #(.WIDTH(W), .K(K), .C(C), .NUM_FILTERS(NF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lb         (bus),
    .rd_valid   (rd_valid),
    .rd_slot    (rd_slot),
    .kernel_out (kernel_out),
    .out_valid  (out_valid),
    .out_err    (out_err),
    .slot_valid (slot_valid)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  mem_m [NF][N];
  logic [NF-1:0] valid_m;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] model_kernel(input int s);
    logic [N*W-1:0] e;
    e = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        for (int ch = 0; ch < C; ch++)
          e[((r * K + c) * C + ch) * W +: W] = mem_m[s][(r * K + c) * C + ch];
    return e;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_kernel"}, kernel_out, 0);
    check({tag, "_sv"}, slot_valid, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_oe"}, out_err, 0);
    check({tag, "_rdy"}, bus.wr_ready, 0);
    check({tag, "_busy"}, bus.load_busy, 0);
    check({tag, "_done"}, bus.load_done, 0);
    check({tag, "_err"}, bus.load_err, 0);
  endtask

  task automatic do_read(input int s, input string tag);
    logic           exp_err;
    logic [N*W-1:0] exp;
    rd_valid = 1'b1;
    rd_slot  = SW'(s);
    tick();
    rd_valid = 1'b0;
    exp_err  = (s >= NF) ? 1'b1 : !valid_m[s];
    exp      = exp_err ? '0 : model_kernel(s);
    check({tag, "_ov"}, out_valid, 1);
    check({tag, "_oe"}, out_err, exp_err);
    check({tag, "_kernel"}, kernel_out, exp);
    tick();
    check({tag, "_ov_pulse"}, out_valid, 0);
    check({tag, "_oe_idle"}, out_err, 0);
    check({tag, "_hold"}, kernel_out, exp);
  endtask

  // mode: 0 = wr_valid held, 1 = every other cycle, 2 = random
  task automatic do_load(input int slot, input int base, input int mode, input int abort_at,
                         input bit abort_last, input bit rd_last, input bit poke, input string tag);
    logic [W-1:0] w [N];
    int acc, cyc;
    bit fin, hs, last_now, was_abort;
    for (int i = 0; i < N; i++) w[i] = W'(base + i);
    acc = 0; cyc = 0; fin = 0;
    bus.load_start = 1'b1;
    bus.load_slot  = SW'(slot);
    tick();
    bus.load_start = 1'b0;
    valid_m[slot]  = 1'b0;
    check({tag, "_busy"}, bus.load_busy, 1);
    check({tag, "_cleared"}, slot_valid, valid_m);
    while (!fin && cyc < 400) begin
      cyc++;
      bus.wr_valid   = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1));
      bus.wr_data    = w[acc];
      bus.load_abort = 1'b0;
      bus.load_start = poke && (acc == 5);
      bus.load_slot  = SW'((slot + 1) % NF);
      if (abort_at >= 0 && acc == abort_at) begin
        bus.wr_valid   = 1'b0;
        bus.load_abort = 1'b1;
      end
      hs       = bus.wr_valid && bus.wr_ready;
      last_now = hs && (acc == N - 1);
      if (last_now && abort_last) bus.load_abort = 1'b1;
      if (last_now && rd_last) begin
        rd_valid = 1'b1;
        rd_slot  = SW'(slot);
      end
      was_abort = bus.load_abort && !last_now;
      tick();
      bus.wr_valid = 1'b0; bus.load_abort = 1'b0; bus.load_start = 1'b0; rd_valid = 1'b0;
      if (hs) acc++;
      if (acc == N) begin
        fin = 1;
        for (int i = 0; i < N; i++) mem_m[slot][i] = w[i];
        valid_m[slot] = 1'b1;
        check({tag, "_done"}, bus.load_done, 1);
        check({tag, "_rdy_after"}, bus.wr_ready, 0);
        check({tag, "_busy_after"}, bus.load_busy, 0);
        check({tag, "_sv"}, slot_valid, valid_m);
        if (rd_last) begin
          check({tag, "_rdlast_ov"}, out_valid, 1);
          check({tag, "_rdlast_oe"}, out_err, 1);
          check({tag, "_rdlast_k"}, kernel_out, 0);
        end
        tick();
        check({tag, "_done_pulse"}, bus.load_done, 0);
      end else if (was_abort) begin
        fin = 1;
        check({tag, "_abort_busy"}, bus.load_busy, 0);
        check({tag, "_abort_done"}, bus.load_done, 0);
        check({tag, "_abort_sv"}, slot_valid, valid_m);
        tick();
        check({tag, "_abort_nodone"}, bus.load_done, 0);
      end else begin
        check({tag, "_early_done"}, bus.load_done, 0);
        check({tag, "_busy_mid"}, bus.load_busy, 1);
      end
    end
    if (!fin) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    int s, m, ab;
    rst_n = 1'b0;
    rd_valid = 1'b0; rd_slot = '0;
    bus.load_start = 1'b0; bus.load_slot = '0; bus.load_abort = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    valid_m = '0;
    for (int i = 0; i < NF; i++) for (int j = 0; j < N; j++) mem_m[i][j] = '0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    do_read(0, "t1_rd0");

    do_load(2, 1, 0, -1, 0, 0, 0, "t2_load");
    check("t2_sv_const", slot_valid, 5'b00100);
    do_read(2, "t2_rd2");
    check("t2_k000", kernel_out[0][0][0], 1);
    check("t2_k002", kernel_out[0][0][2], 3);
    check("t2_k010", kernel_out[0][1][0], 4);
    check("t2_k222", kernel_out[2][2][2], 27);

    do_load(1, $urandom_range(0, 255), 1, -1, 0, 0, 0, "t3_load");
    do_read(1, "t3_rd1");

    do_load(3, 50, 0, 10, 0, 0, 0, "t4_abort");
    do_read(3, "t4_rd3_err");
    do_load(3, 100, 0, -1, 0, 0, 0, "t4_reload");
    do_read(3, "t4_rd3");

    for (int b = 5; b < 8; b++) begin
      bus.load_start = 1'b1;
      bus.load_slot  = SW'(b);
      tick();
      bus.load_start = 1'b0;
      check("t5_err_pulse", bus.load_err, 1);
      check("t5_err_busy", bus.load_busy, 0);
      tick();
      check("t5_err_once", bus.load_err, 0);
      check("t5_err_sv", slot_valid, valid_m);
    end
    bus.load_abort = 1'b1;
    tick();
    bus.load_abort = 1'b0;
    check("t5_idle_abort", bus.load_busy, 0);
    do_read(6, "t5_rd_oor");
    do_load(4, $urandom_range(0, 255), 2, -1, 0, 0, 1, "t5_poke");
    do_read(4, "t5_rd4");

    do_load(0, $urandom_range(0, 255), 0, -1, 1, 0, 0, "t_abort_last");
    do_read(0, "t_rd0_al");
    do_load(1, $urandom_range(0, 255), 2, -1, 0, 1, 0, "t_rd_last");
    do_read(1, "t_rd1_new");

    for (int it = 0; it < 24; it++) begin
      s = $urandom_range(0, 7);
      m = $urandom_range(0, 2);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      if ($urandom_range(0, 1) == 1 && s < NF)
        do_load(s, $urandom_range(0, 255), m, ab, 0, 0, 0, "rnd_load");
      else
        do_read(s, "rnd_read");
    end

    do_load(2, $urandom_range(0, 255), 0, -1, 0, 0, 0, "t6_pre2");
    do_load(0, $urandom_range(0, 255), 0, -1, 0, 0, 0, "t6_pre0");
    do_read(0, "t6_rdA");
    bus.load_start = 1'b1;
    bus.load_slot  = SW'(0);
    tick();
    bus.load_start = 1'b0;
    valid_m[0] = 1'b0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = W'($urandom_range(0, 255));
      tick();
    end
    bus.wr_valid = 1'b0;
    do_read(0, "t6_rd0_mid");
    do_read(2, "t6_rd2_mid");
    check("t6_still_busy", bus.load_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    valid_m = '0;
    check_zero_outputs("t6_reset");
    tick();
    rst_n = 1'b1;
    tick();
    do_read(2, "t6_rd2_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
